// File: rtl/chess_pkg.sv
// Shared piece codes, board geometry defaults and the power-on board layout
// for the chess display render path.
package chess_pkg;

  typedef enum logic [3:0] {
    PC_EMPTY = 4'd0,
    PC_WP    = 4'd1,
    PC_WN    = 4'd2,
    PC_WB    = 4'd3,
    PC_WR    = 4'd4,
    PC_WQ    = 4'd5,
    PC_WK    = 4'd6,
    PC_BP    = 4'd9,
    PC_BN    = 4'd10,
    PC_BB    = 4'd11,
    PC_BR    = 4'd12,
    PC_BQ    = 4'd13,
    PC_BK    = 4'd14
  } piece_t;

  localparam int SQ_SIZE  = 60;
  localparam int BOARD_X0 = 80;
  localparam int V_ACTIVE = 480;

  // Index is row*8+col with row 0 at the top (rank 8, black back rank).
  localparam logic [3:0] INIT_BOARD [64] = '{
    PC_BR, PC_BN, PC_BB, PC_BQ, PC_BK, PC_BB, PC_BN, PC_BR,
    PC_BP, PC_BP, PC_BP, PC_BP, PC_BP, PC_BP, PC_BP, PC_BP,
    PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY,
    PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY,
    PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY,
    PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY,
    PC_WP, PC_WP, PC_WP, PC_WP, PC_WP, PC_WP, PC_WP, PC_WP,
    PC_WR, PC_WN, PC_WB, PC_WQ, PC_WK, PC_WB, PC_WN, PC_WR
  };

  // Square index along one axis: a threshold ladder instead of a divider,
  // saturating at 7 for coordinates past the board edge.
  function automatic logic [2:0] cell_of(input logic [9:0] v, input int sq);
    logic [2:0] c;
    c = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(v) >= k * sq) c = 3'(k);
    end
    return c;
  endfunction

endpackage

// File: rtl/board_upd_fifo.sv
// Synchronous FIFO holding pending {square, piece} board updates.
// DEPTH must be a power of two, at least 2.
module board_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/board_render_ctrl.sv
// Owns the 8x8 board, applies queued updates only in vertical blank, and
// produces per-pixel sprite address / piece / square colour two cycles later.
module board_render_ctrl #(
  parameter int BOARD_X0   = chess_pkg::BOARD_X0,
  parameter int SQ         = chess_pkg::SQ_SIZE,
  parameter int V_ACTIVE   = chess_pkg::V_ACTIVE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        upd_valid,
  input  logic [5:0]  upd_sq,
  input  logic [3:0]  upd_piece,
  output logic        upd_ready,
  output logic [11:0] sprite_addr,
  output logic [3:0]  sprite_piece,
  output logic        sq_dark,
  output logic        in_board
);

  import chess_pkg::*;

  logic [9:0] w_fifo_rd;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;

  assign w_push    = upd_valid & ~w_full;
  assign w_pop     = (DrawY >= 10'(V_ACTIVE)) & ~w_empty;
  assign upd_ready = ~w_full;

  board_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .i_clk   (vga_clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({upd_sq, upd_piece}),
    .o_rdata (w_fifo_rd),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Writes happen only in vertical blank, so the render read never races them.
  logic [3:0] r_board [64];

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) r_board[i] <= INIT_BOARD[i];
    end else if (w_pop) begin
      r_board[w_fifo_rd[9:4]] <= w_fifo_rd[3:0];
    end
  end

  logic [9:0] w_dx;
  logic       w_hit;
  logic [2:0] w_col;
  logic [2:0] w_row;
  logic [5:0] w_lx;
  logic [5:0] w_ly;

  assign w_dx  = DrawX - 10'(BOARD_X0);
  assign w_hit = blank & (DrawX >= 10'(BOARD_X0)) & (DrawX < 10'(BOARD_X0 + 8*SQ))
               & (DrawY < 10'(8*SQ));
  assign w_col = cell_of(w_dx, SQ);
  assign w_row = cell_of(DrawY, SQ);
  assign w_lx  = 6'(w_dx - 10'(w_col) * 10'(SQ));
  assign w_ly  = 6'(DrawY - 10'(w_row) * 10'(SQ));

  logic       r_hit;
  logic [2:0] r_col;
  logic [2:0] r_row;
  logic [5:0] r_lx;
  logic [5:0] r_ly;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hit <= 1'b0;
      r_col <= '0;
      r_row <= '0;
      r_lx  <= '0;
      r_ly  <= '0;
    end else begin
      r_hit <= w_hit;
      r_col <= w_col;
      r_row <= w_row;
      r_lx  <= w_lx;
      r_ly  <= w_ly;
    end
  end

  logic [3:0]  w_piece;
  logic [11:0] w_addr;

  assign w_piece = r_board[{r_row, r_col}];
  assign w_addr  = 12'(r_ly) * 12'(SQ) + 12'(r_lx);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sprite_addr  <= '0;
      sprite_piece <= '0;
      sq_dark      <= 1'b0;
      in_board     <= 1'b0;
    end else begin
      in_board <= r_hit;
      if (r_hit) begin
        sprite_addr  <= w_addr;
        sprite_piece <= w_piece;
        sq_dark      <= r_row[0] ^ r_col[0];
      end else begin
        sprite_addr  <= '0;
        sprite_piece <= '0;
        sq_dark      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_board_render_ctrl.sv
// Self-checking bench for board_render_ctrl: directed scenarios plus random
// pixels/updates compared against a frame-level board and queue model.
module tb_board_render_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b0;
  logic        upd_valid = 1'b0;
  logic [5:0]  upd_sq = '0;
  logic [3:0]  upd_piece = '0;
  logic        upd_ready;
  logic [11:0] sprite_addr;
  logic [3:0]  sprite_piece;
  logic        sq_dark;
  logic        in_board;

  board_render_ctrl #(
    .BOARD_X0   (80),
    .SQ         (60),
    .V_ACTIVE   (480),
    .FIFO_DEPTH (4)
  ) dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .upd_valid    (upd_valid),
    .upd_sq       (upd_sq),
    .upd_piece    (upd_piece),
    .upd_ready    (upd_ready),
    .sprite_addr  (sprite_addr),
    .sprite_piece (sprite_piece),
    .sq_dark      (sq_dark),
    .in_board     (in_board)
  );

  always #5 vga_clk = ~vga_clk;

  int n_total = 0;
  int n_bad = 0;

  int bm [64];
  int q [$];
  int p1_x, p1_y;
  bit p1_b;
  int e_addr, e_piece, e_dark, e_in;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void board_reset();
    int top [8] = '{12, 10, 11, 13, 14, 11, 10, 12};
    int bot [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int i = 0; i < 64; i++) begin
      int r = i / 8;
      int c = i % 8;
      bm[i] = (r == 0) ? top[c] : (r == 1) ? 9 : (r == 6) ? 1 : (r == 7) ? bot[c] : 0;
    end
  endfunction

  // One clock edge of the reference: outputs reflect the pixel seen one edge
  // earlier against the board as it stood before this edge's write.
  function automatic void model_edge();
    bit rdy;
    if (reset) begin
      board_reset();
      q.delete();
      p1_x = 0; p1_y = 0; p1_b = 0;
      e_addr = 0; e_piece = 0; e_dark = 0; e_in = 0;
      return;
    end
    if (p1_b && p1_x >= 80 && p1_x < 560 && p1_y < 480) begin
      int c = (p1_x - 80) / 60;
      int r = p1_y / 60;
      e_piece = bm[r*8 + c];
      e_addr  = (p1_y % 60) * 60 + (p1_x - 80) % 60;
      e_dark  = (r + c) % 2;
      e_in    = 1;
    end else begin
      e_piece = 0; e_addr = 0; e_dark = 0; e_in = 0;
    end
    p1_x = int'(DrawX);
    p1_y = int'(DrawY);
    p1_b = blank;
    rdy = (q.size() < 4);
    if (int'(DrawY) >= 480 && q.size() > 0) begin
      int e = q.pop_front();
      bm[e / 16] = e % 16;
    end
    if (upd_valid && rdy) q.push_back(int'(upd_sq) * 16 + int'(upd_piece));
  endfunction

  task automatic cycle();
    @(posedge vga_clk);
    model_edge();
    #1;
    check_val("piece", int'(sprite_piece), e_piece);
    check_val("addr", int'(sprite_addr), e_addr);
    check_val("dark", int'(sq_dark), e_dark);
    check_val("in_board", int'(in_board), e_in);
    check_val("ready", int'(upd_ready), (q.size() < 4) ? 1 : 0);
  endtask

  task automatic settle(input int n);
    repeat (n) cycle();
  endtask

  task automatic drive(input int x, input int y, input bit b, input bit v,
                       input int s, input int p);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    upd_valid = v;
    upd_sq = 6'(s);
    upd_piece = 4'(p);
  endtask

  int bx [4] = '{79, 560, 300, 300};
  int by [4] = '{100, 100, 480, 100};
  bit bb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    board_reset();
    drive(0, 0, 0, 0, 0, 0);
    settle(3);
    check_val("rst_ready", int'(upd_ready), 1);
    check_val("rst_in_board", int'(in_board), 0);
    check_val("rst_addr", int'(sprite_addr), 0);
    reset = 1'b0;

    for (int x = 80; x < 560; x++) begin
      drive(x, 0, 1, 0, 0, 0);
      cycle();
    end
    settle(2);

    drive(80, 0, 1, 0, 0, 0);   settle(2);
    check_val("sweep_first_piece", int'(sprite_piece), 12);
    check_val("sweep_first_dark", int'(sq_dark), 0);
    drive(140, 0, 1, 0, 0, 0);  settle(2);
    check_val("sweep_second_piece", int'(sprite_piece), 10);
    check_val("sweep_second_dark", int'(sq_dark), 1);
    drive(559, 0, 1, 0, 0, 0);  settle(2);
    check_val("sweep_last_piece", int'(sprite_piece), 12);
    drive(139, 59, 1, 0, 0, 0); settle(2);
    check_val("addr_max", int'(sprite_addr), 3599);
    drive(140, 60, 1, 0, 0, 0); settle(2);
    check_val("addr_zero", int'(sprite_addr), 0);
    check_val("row1_pawn", int'(sprite_piece), 9);

    for (int i = 0; i < 4; i++) begin
      drive(bx[i], by[i], bb[i], 0, 0, 0);
      settle(2);
      check_val("edge_in_board", int'(in_board), 0);
      check_val("edge_addr", int'(sprite_addr), 0);
      check_val("edge_piece", int'(sprite_piece), 0);
    end

    // Updates queued mid-frame must not show until vertical blank.
    drive(200, 100, 1, 1, 52, 0); cycle();
    drive(200, 100, 1, 1, 36, 1); cycle();
    drive(320, 370, 1, 0, 0, 0);  settle(3);
    check_val("hold_sq52", int'(sprite_piece), 1);
    drive(320, 479, 1, 0, 0, 0);  settle(2);
    drive(0, 480, 0, 0, 0, 0);    settle(2);
    check_val("drain_ready", int'(upd_ready), 1);
    drive(320, 370, 1, 0, 0, 0);  settle(2);
    check_val("applied_sq52", int'(sprite_piece), 0);
    drive(320, 250, 1, 0, 0, 0);  settle(2);
    check_val("applied_sq36", int'(sprite_piece), 1);

    // Fill the queue during active video, then hold valid into blank.
    drive(100, 100, 1, 1, 10, 7);  cycle();
    drive(100, 100, 1, 1, 20, 8);  cycle();
    drive(100, 100, 1, 1, 30, 15); cycle();
    drive(100, 100, 1, 1, 40, 3);  cycle();
    check_val("fill_ready", int'(upd_ready), 0);
    drive(100, 100, 1, 1, 41, 5);  settle(3);
    check_val("full_hold_ready", int'(upd_ready), 0);
    drive(100, 480, 1, 1, 41, 5);  settle(6);
    drive(100, 490, 0, 0, 0, 0);   settle(6);
    for (int i = 0; i < 4; i++) begin
      drive(80 + 60*i + 30, 60 + 30, 1, 0, 0, 0);
      settle(2);
    end

    // Mid-frame reset with pending updates discards them.
    drive(200, 200, 1, 1, 0, 0); cycle();
    drive(200, 200, 1, 1, 1, 0); cycle();
    drive(200, 200, 1, 1, 2, 0); cycle();
    drive(200, 200, 1, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check_val("midrst_ready", int'(upd_ready), 1);
    check_val("midrst_in_board", int'(in_board), 0);
    settle(2);
    reset = 1'b0;
    drive(200, 200, 1, 0, 0, 0);
    cycle();
    check_val("post_rst_first", int'(in_board), 0);
    drive(0, 480, 0, 0, 0, 0); settle(5);
    for (int i = 0; i < 64; i++) begin
      drive(80 + (i % 8)*60 + 30, (i / 8)*60 + 30, 1, 0, 0, 0);
      settle(2);
      check_val("rst_board", int'(sprite_piece), bm[i]);
    end

    // Random pixels, blanking and updates.
    for (int n = 0; n < 4000; n++) begin
      int y;
      y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 524)) : int'($urandom_range(0, 479));
      drive(int'($urandom_range(0, 639)), y, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 15)));
      cycle();
    end
    drive(0, 480, 0, 0, 0, 0); settle(6);
    for (int i = 0; i < 64; i++) begin
      drive(80 + (i % 8)*60 + 17, (i / 8)*60 + 43, 1, 0, 0, 0);
      settle(2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
